// File: rtl/alb_pkg.sv
// Shared opcode encoding and flag bundle for the ALU pipeline (alb_core, alb_pipe).
package alb_pkg;

  typedef enum logic [1:0] {
    OP_OR     = 2'b00,
    OP_ADD    = 2'b01,
    OP_ANDNOT = 2'b10,
    OP_SUB    = 2'b11
  } alb_op_e;

  typedef struct packed {
    logic co;
    logic vo;
    logic no;
    logic zo;
  } alb_flags_t;

  // Flag state shown while the output stage is empty after reset.
  localparam alb_flags_t FLAGS_RESET = '{co: 1'b0, vo: 1'b0, no: 1'b0, zo: 1'b1};

endpackage

// File: rtl/alb_core.sv
// Combinational ALU: OR / ADD / ANDNOT / SUB with carry, overflow, negative, zero flags.
// Build option ALB_SAT_EN clamps overflowing ADD/SUB results to the signed limits.
module alb_core
  import alb_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] s,
  input  logic             ci,
  input  alb_op_e          op,
  output logic [WIDTH-1:0] f,
  output alb_flags_t       flags
);

  logic                    arith;
  logic                    ovf;
  logic [WIDTH-1:0]        s_eff;
  logic [WIDTH:0]          sum;
  logic signed [WIDTH-1:0] raw;

`ifdef ALB_SAT_EN
  // On overflow both operands share a sign, and that sign is the sign of the true result.
  function automatic logic signed [WIDTH-1:0] saturate(
    input logic signed [WIDTH-1:0] val,
    input logic                    overflow,
    input logic                    neg
  );
    if (!overflow) return val;
    return neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  endfunction
`endif

  always_comb begin
    arith = (op == OP_ADD) || (op == OP_SUB);
    s_eff = (op == OP_SUB) ? ~s : s;
    sum   = {1'b0, r} + {1'b0, s_eff} + {{WIDTH{1'b0}}, ci};
    raw   = $signed(sum[WIDTH-1:0]);
    ovf   = arith && (r[WIDTH-1] == s_eff[WIDTH-1]) && (raw[WIDTH-1] != r[WIDTH-1]);

    case (op)
      OP_OR:     f = r | s;
      OP_ANDNOT: f = ~r & s;
`ifdef ALB_SAT_EN
      default:   f = saturate(raw, ovf, r[WIDTH-1]);
`else
      default:   f = raw;
`endif
    endcase

    flags.co = arith & sum[WIDTH];
    flags.vo = ovf;
    flags.no = f[WIDTH-1];
    flags.zo = (f == '0);
  end

endmodule

// File: rtl/alb_pipe.sv
// Two-stage valid/ready ALU pipeline with an accumulator fed back as the R operand.
// Build option ALB_SAT_EN (handled in alb_core) selects saturating ADD/SUB.
module alb_pipe
  import alb_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] ACC_RESET = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] R_in,
  input  logic [WIDTH-1:0] S_in,
  input  logic             CI,
  input  logic [1:0]       I,
  input  logic             ACC_SEL,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] F_ALB,
  output logic             CO,
  output logic             VO,
  output logic             NO,
  output logic             ZO,
  output logic [WIDTH-1:0] ACC
);

  logic             accept;
  logic             load_p2;

  logic             vld_p1;
  logic [WIDTH-1:0] r_p1;
  logic [WIDTH-1:0] s_p1;
  logic             ci_p1;
  alb_op_e          op_p1;
  logic             acc_sel_p1;

  logic [WIDTH-1:0] r_core;
  logic [WIDTH-1:0] f_core;
  alb_flags_t       flags_core;

  logic             vld_p2;
  logic [WIDTH-1:0] f_p2;
  alb_flags_t       flags_p2;
  logic [WIDTH-1:0] acc_p2;

  // S2 accepts whenever it is empty or its current result leaves this cycle.
  assign load_p2  = vld_p1 && (!vld_p2 || out_ready);
  assign in_ready = !vld_p1 || load_p2;
  assign accept   = in_valid && in_ready;

  // ---- S1: capture operands at accept ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1 <= 1'b0;
    end else if (accept) begin
      vld_p1 <= 1'b1;
    end else if (load_p2) begin
      vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      r_p1       <= R_in;
      s_p1       <= S_in;
      ci_p1      <= CI;
      op_p1      <= alb_op_e'(I);
      acc_sel_p1 <= ACC_SEL;
    end
  end

  // ---- S1 -> S2: compute, accumulator read at the transfer edge ----
  // ACC is written by every S2 load, so a chained op in S1 always sees its predecessor.
  assign r_core = acc_sel_p1 ? acc_p2 : r_p1;

  alb_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .r     (r_core),
    .s     (s_p1),
    .ci    (ci_p1),
    .op    (op_p1),
    .f     (f_core),
    .flags (flags_core)
  );

  // ---- S2: result, flags and accumulator ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p2   <= 1'b0;
      f_p2     <= '0;
      flags_p2 <= FLAGS_RESET;
      acc_p2   <= ACC_RESET;
    end else if (load_p2) begin
      vld_p2   <= 1'b1;
      f_p2     <= f_core;
      flags_p2 <= flags_core;
      acc_p2   <= f_core;
    end else if (out_ready) begin
      vld_p2   <= 1'b0;
    end
  end

  assign out_valid = vld_p2;
  assign F_ALB     = f_p2;
  assign CO        = flags_p2.co;
  assign VO        = flags_p2.vo;
  assign NO        = flags_p2.no;
  assign ZO        = flags_p2.zo;
  assign ACC       = acc_p2;

endmodule

// File: tb/tb_alb_pipe.sv
// Self-checking bench for alb_pipe (WIDTH=8): integer reference model, in-order result queue.
module tb_alb_pipe;

  localparam logic [7:0] ACC_RST = 8'h00;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] r_in = 8'h00;
  logic [7:0] s_in = 8'h00;
  logic       ci = 1'b0;
  logic [1:0] op = 2'b00;
  logic       acc_sel = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] f_alb;
  logic       co, vo, no, zo;
  logic [7:0] acc;

  alb_pipe #(.WIDTH(8), .ACC_RESET(ACC_RST)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .R_in(r_in), .S_in(s_in), .CI(ci), .I(op), .ACC_SEL(acc_sel),
    .out_valid(out_valid), .out_ready(out_ready), .F_ALB(f_alb),
    .CO(co), .VO(vo), .NO(no), .ZO(zo), .ACC(acc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] f;
    logic       co, vo, no, zo;
    int         cyc;
  } res_t;

  res_t       exp_q[$];
  res_t       del_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [7:0] model_acc = ACC_RST;
  logic       last_acc = 1'b0;

  logic [7:0] bp_r [4] = '{8'h01, 8'h10, 8'h0F, 8'h05};
  logic [7:0] bp_s [4] = '{8'h02, 8'h20, 8'hFF, 8'h03};
  logic [1:0] bp_o [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
  logic       bp_c [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic [7:0] bp_f [4] = '{8'h03, 8'h30, 8'hF0, 8'h02};
  logic [7:0] edge_v [4] = '{8'h7F, 8'h80, 8'hFF, 8'h00};

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain integer arithmetic, unsigned for carry and signed for overflow.
  function automatic res_t model(input logic [7:0] r, input logic [7:0] s,
                                 input logic c, input logic [1:0] o);
    res_t e;
    int ur, us, sr, ss, tu, ts;
    ur = int'(r);
    us = int'(s);
    sr = (ur >= 128) ? ur - 256 : ur;
    ss = (us >= 128) ? us - 256 : us;
    e.co = 1'b0; e.vo = 1'b0; e.cyc = 0;
    case (o)
      2'b00: e.f = r | s;
      2'b10: e.f = ~r & s;
      default: begin
        if (o == 2'b01) begin
          tu = ur + us + int'(c);
          ts = sr + ss + int'(c);
        end else begin
          tu = ur + (255 - us) + int'(c);
          ts = sr - ss - 1 + int'(c);
        end
        e.f  = tu[7:0];
        e.co = (tu > 255);
        e.vo = (ts > 127) || (ts < -128);
`ifdef ALB_SAT_EN
        if (e.vo) e.f = (ts > 0) ? 8'h7F : 8'h80;
`endif
      end
    endcase
    e.no = e.f[7];
    e.zo = (e.f == 8'h00);
    return e;
  endfunction

  function automatic logic [7:0] pick();
    if ($urandom_range(3) == 0) return edge_v[$urandom_range(3)];
    return 8'($urandom_range(255));
  endfunction

  // One clock cycle: called at a falling edge with inputs already driven.
  task automatic step();
    int   n;
    logic exp_ov;
    res_t e;
    #1;
    n = exp_q.size();
    exp_ov = 1'b0;
    if (n > 0) exp_ov = (cyc >= exp_q[0].cyc + 2);
    chk("out_valid", out_valid, exp_ov);
    chk("in_ready", in_ready, !(n >= 2 && !out_ready));
    if (out_valid && n > 0) begin
      chk("F_ALB", f_alb, exp_q[0].f);
      chk("CO", co, exp_q[0].co);
      chk("VO", vo, exp_q[0].vo);
      chk("NO", no, exp_q[0].no);
      chk("ZO", zo, exp_q[0].zo);
      chk("ACC", acc, exp_q[0].f);
    end
    last_acc = in_valid && in_ready;
    if (out_valid && out_ready && n > 0) begin
      e = exp_q.pop_front();
      e.f = f_alb; e.co = co; e.vo = vo; e.no = no; e.zo = zo; e.cyc = cyc;
      del_q.push_back(e);
    end
    if (last_acc) begin
      e = model(acc_sel ? model_acc : r_in, s_in, ci, op);
      e.cyc = cyc;
      model_acc = e.f;
      exp_q.push_back(e);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst out_valid", out_valid, 0);
    chk("rst ACC", acc, ACC_RST);
    chk("rst F_ALB", f_alb, 0);
    chk("rst ZO", zo, 1);
    chk("rst CO/VO/NO", {co, vo, no}, 0);
    chk("rst in_ready", in_ready, 1);
    exp_q.delete();
    model_acc = ACC_RST;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_op(input logic [7:0] r, input logic [7:0] s, input logic c,
                        input logic [1:0] o, input logic as, output res_t got);
    int nd;
    nd = del_q.size();
    r_in = r; s_in = s; ci = c; op = o; acc_sel = as;
    in_valid = 1'b1; out_ready = 1'b1;
    step();
    chk("run_op accepted", last_acc, 1);
    in_valid = 1'b0; acc_sel = 1'b0;
    for (int k = 0; k < 10 && del_q.size() == nd; k++) step();
    got = '{f: 8'h00, co: 1'b0, vo: 1'b0, no: 1'b0, zo: 1'b0, cyc: 0};
    if (del_q.size() == nd) chk("run_op result timeout", 0, 1);
    else got = del_q[nd];
  endtask

  initial begin
    res_t got;
    int   nd, idx;

    @(negedge clk);
    do_reset();

    // Basic operations with hand-computed results
    run_op(8'h0A, 8'h05, 1'b0, 2'b00, 1'b0, got);
    chk("lit OR F", got.f, 8'h0F);
    chk("lit OR flags", {got.co, got.vo, got.no, got.zo}, 4'b0000);

    run_op(8'h7F, 8'h01, 1'b0, 2'b01, 1'b0, got);
`ifdef ALB_SAT_EN
    chk("lit ADD ovf F", got.f, 8'h7F);
    chk("lit ADD ovf flags", {got.co, got.vo, got.no, got.zo}, 4'b0100);
`else
    chk("lit ADD ovf F", got.f, 8'h80);
    chk("lit ADD ovf flags", {got.co, got.vo, got.no, got.zo}, 4'b0110);
`endif

    run_op(8'h01, 8'h01, 1'b1, 2'b11, 1'b0, got);
    chk("lit SUB zero F", got.f, 8'h00);
    chk("lit SUB zero flags", {got.co, got.vo, got.no, got.zo}, 4'b1001);

    run_op(8'h01, 8'h02, 1'b1, 2'b11, 1'b0, got);
    chk("lit SUB neg F", got.f, 8'hFF);
    chk("lit SUB neg flags", {got.co, got.vo, got.no, got.zo}, 4'b0010);

    // Accumulator chain: three back-to-back ACC_SEL adds
    do_reset();
    nd = del_q.size();
    r_in = 8'hEE; s_in = 8'h10; ci = 1'b0; op = 2'b01; acc_sel = 1'b1;
    in_valid = 1'b1; out_ready = 1'b1;
    repeat (3) step();
    in_valid = 1'b0; acc_sel = 1'b0;
    for (int k = 0; k < 10 && del_q.size() < nd + 3; k++) step();
    if (del_q.size() < nd + 3) chk("acc chain timeout", 0, 1);
    else begin
      chk("acc chain r0", del_q[nd].f, 8'h10);
      chk("acc chain r1", del_q[nd+1].f, 8'h20);
      chk("acc chain r2", del_q[nd+2].f, 8'h30);
      chk("acc chain spacing", del_q[nd+2].cyc - del_q[nd].cyc, 2);
      chk("acc chain ACC", acc, 8'h30);
    end

    // Backpressure: output stalled for 5 cycles under a 4-op stream
    nd = del_q.size();
    idx = 0;
    for (int k = 0; k < 5; k++) begin
      out_ready = 1'b0;
      in_valid = (idx < 4);
      if (idx < 4) begin r_in = bp_r[idx]; s_in = bp_s[idx]; op = bp_o[idx]; ci = bp_c[idx]; end
      step();
      if (last_acc) idx++;
    end
    chk("bp accepts while stalled", idx, 2);
    for (int k = 0; k < 20 && del_q.size() < nd + 4; k++) begin
      out_ready = 1'b1;
      in_valid = (idx < 4);
      if (idx < 4) begin r_in = bp_r[idx]; s_in = bp_s[idx]; op = bp_o[idx]; ci = bp_c[idx]; end
      step();
      if (last_acc) idx++;
    end
    in_valid = 1'b0;
    chk("bp delivered", del_q.size() - nd, 4);
    if (del_q.size() >= nd + 4)
      for (int k = 0; k < 4; k++) chk("bp result", del_q[nd+k].f, bp_f[k]);

    // Reset with two operations in flight
    r_in = 8'h33; s_in = 8'h11; op = 2'b01; ci = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    step();
    r_in = 8'h40; s_in = 8'h02;
    step();
    in_valid = 1'b0;
    chk("pre-reset out_valid", out_valid, 1);
    chk("pre-reset ACC", acc, 8'h44);
    do_reset();
    repeat (6) step();

    // Randomised traffic with one reset partway through
    for (int k = 0; k < 3000; k++) begin
      if (k == 1500) do_reset();
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      r_in      = pick();
      s_in      = pick();
      ci        = 1'($urandom_range(1));
      op        = 2'($urandom_range(3));
      acc_sel   = ($urandom_range(2) == 0);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (5) step();
    chk("drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
